// File: rtl/genetic_breeder.sv
// Breeds rows H..2H-1 of a sorted population from parent rows 0..H-1 (crossover + mutation).
// Each gene takes two reads, a mix cycle and a write; every transfer waits on ramReady with no timeout.
module genetic_breeder #(
    parameter int          INPUT_COUNT             = 2,
    parameter int          OUTPUT_COUNT            = 1,
    parameter int          NEURON_COUNT            = 5,
    parameter int          CONNECTIONS             = 2,
    parameter int          NETWORKS_PER_POPULATION = 16,
    parameter logic [8:0]  MUTATION_RATE           = 9'd8,
    parameter logic [15:0] LFSR_SEED               = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  networkState,
    output logic        finished,
    input  logic [15:0] ramBusDataOut,
    output logic [15:0] ramBusDataIn,
    output logic [22:0] ramBusAddr,
    output logic        ramLatch,
    output logic        ramInstruction,
    input  logic        ramReady
);

    // Network inputs do not contribute genes; only neuron weights and outputs do.
    localparam int G = OUTPUT_COUNT + NEURON_COUNT * CONNECTIONS + 0 * INPUT_COUNT;
    localparam int H = NETWORKS_PER_POPULATION / 2;

    localparam logic [22:0] GENE_STRIDE = 23'(G);
    localparam logic [7:0]  LAST_GENE   = 8'(G - 1);
    localparam logic [5:0]  FIRST_CHILD = 6'(H);
    localparam logic [5:0]  LAST_CHILD  = 6'(2 * H - 1);
    localparam logic [5:0]  LAST_PARENT = 6'(H - 1);

    typedef enum logic [3:0] {
        IDLE, RD_A, WT_A, RD_B, WT_B, MIX, WR, WT_W, NEXT, DONE
    } stateT;

    stateT       state, stateNext;
    logic        active;
    logic [5:0]  child, parentA, parentB;
    logic [7:0]  gene;
    logic [15:0] lfsr, lfsrNext, gA, gB, childGene, selGene, mixGene, dataReg;
    logic [22:0] addrReg;
    logic        latchReg, instrReg, finishedReg, mutate, readyOk;

    function automatic logic [22:0] geneAddr(input logic [5:0] net, input logic [7:0] g);
        return 23'(net) * GENE_STRIDE + 23'(g);
    endfunction

    assign active   = (networkState == 2'd3);
    assign parentA  = child - FIRST_CHILD;
    assign parentB  = (parentA == LAST_PARENT) ? 6'd0 : parentA + 6'd1;
    // A ready seen while the strobe is still high belongs to an earlier request.
    assign readyOk  = ramReady && !latchReg;
    assign lfsrNext = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    assign selGene  = lfsr[0] ? gB : gA;
    assign mutate   = {1'b0, lfsr[7:0]} < MUTATION_RATE;
    assign mixGene  = mutate ? (selGene ^ (16'h1 << lfsr[11:8])) : selGene;

    assign finished       = finishedReg;
    assign ramBusAddr     = active ? addrReg  : {23{1'bz}};
    assign ramBusDataIn   = active ? dataReg  : {16{1'bz}};
    assign ramLatch       = active ? latchReg : 1'bz;
    assign ramInstruction = active ? instrReg : 1'bz;

    always_comb begin
        stateNext = state;
        if (!active) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (!finishedReg) stateNext = RD_A;
                RD_A:    stateNext = WT_A;
                WT_A:    if (readyOk) stateNext = RD_B;
                RD_B:    stateNext = WT_B;
                WT_B:    if (readyOk) stateNext = MIX;
                MIX:     stateNext = WR;
                WR:      stateNext = WT_W;
                WT_W:    if (readyOk) stateNext = NEXT;
                NEXT:    stateNext = (gene < LAST_GENE || child < LAST_CHILD) ? RD_A : DONE;
                DONE:    stateNext = DONE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            finishedReg <= 1'b0;
            latchReg    <= 1'b0;
            instrReg    <= 1'b0;
            addrReg     <= '0;
            dataReg     <= '0;
            gA          <= '0;
            gB          <= '0;
            childGene   <= '0;
            lfsr        <= LFSR_SEED;
            child       <= FIRST_CHILD;
            gene        <= '0;
        end else begin
            state    <= stateNext;
            latchReg <= 1'b0;
            if (!active) begin
                finishedReg <= 1'b0;
                child       <= FIRST_CHILD;
                gene        <= '0;
            end else begin
                case (state)
                    RD_A: begin
                        addrReg  <= geneAddr(parentA, gene);
                        instrReg <= 1'b0;
                        latchReg <= 1'b1;
                    end
                    WT_A: if (readyOk) gA <= ramBusDataOut;
                    RD_B: begin
                        addrReg  <= geneAddr(parentB, gene);
                        instrReg <= 1'b0;
                        latchReg <= 1'b1;
                    end
                    WT_B: if (readyOk) gB <= ramBusDataOut;
                    MIX: begin
                        childGene <= mixGene;
                        lfsr      <= lfsrNext;
                    end
                    WR: begin
                        addrReg  <= geneAddr(child, gene);
                        instrReg <= 1'b1;
                        dataReg  <= childGene;
                        latchReg <= 1'b1;
                    end
                    NEXT: begin
                        if (gene < LAST_GENE) begin
                            gene <= gene + 8'd1;
                        end else if (child < LAST_CHILD) begin
                            gene  <= '0;
                            child <= child + 6'd1;
                        end else begin
                            finishedReg <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_genetic_breeder.sv
// Two breeders (mutation off / mutation always) against behavioural RAMs with configurable ready latency.
module tb_genetic_breeder;

    localparam int GENES = 11;
    localparam int WORDS = 16 * GENES;
    localparam int LOGN  = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ns [2];
    int          lat [2];
    logic [15:0] mem [2][WORDS];
    logic [15:0] expImg [2][WORDS];
    int          strobes [2];
    int          widthErr [2];
    int          stabErr [2];
    logic [22:0] stAddr [2][LOGN];
    logic        stInst [2][LOGN];
    wire         fin [2];
    int          checks, errors;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : gRam
        wire [15:0] wdW;
        wire [22:0] addrW;
        wire        latW, instW, finW;
        logic       rdy = 1'b0;
        logic [15:0] rdData = '0;
        logic       pend = 1'b0, prevL = 1'b0;
        int         cnt = 0;
        logic [22:0] cA;
        logic [15:0] cD;
        logic       cI;

        assign fin[k] = finW;

        genetic_breeder #(.MUTATION_RATE(k == 0 ? 9'd0 : 9'd256)) u (
            .clk(clk), .rst_n(rst_n), .networkState(ns[k]), .finished(finW),
            .ramBusDataOut(rdData), .ramBusDataIn(wdW), .ramBusAddr(addrW),
            .ramLatch(latW), .ramInstruction(instW), .ramReady(rdy)
        );

        always @(posedge clk) begin
            rdy <= 1'b0;
            if (ns[k] != 2'd3) pend = 1'b0;
            if (latW === 1'b1) begin
                if (prevL) widthErr[k]++;
                if (strobes[k] < LOGN) begin
                    stAddr[k][strobes[k]] = addrW;
                    stInst[k][strobes[k]] = instW;
                end
                strobes[k]++;
                pend = 1'b1;
                cnt  = lat[k];
                cA = addrW; cD = wdW; cI = instW;
            end else if (pend) begin
                if (addrW !== cA || instW !== cI || (cI && wdW !== cD)) stabErr[k]++;
                cnt--;
            end
            if (pend && cnt == 0) begin
                rdy <= 1'b1;
                if (cI) mem[k][cA[7:0]] = cD;
                else    rdData <= mem[k][cA[7:0]];
                pend = 1'b0;
            end
            prevL = (latW === 1'b1);
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [15:0] parentVal(input int k, input int net);
        return (k == 0) ? 16'h1000 + 16'(net) : 16'h0000;
    endfunction

    task automatic initMem(input int k);
        for (int i = 0; i < WORDS; i++)
            mem[k][i] = (i < 8 * GENES) ? parentVal(k, i / GENES) : 16'hDEAD;
    endtask

    task automatic modelImage(input int k, input logic [15:0] seed, input int rate,
                              output logic [15:0] lfOut);
        logic [15:0] lf, sel;
        int pa, pb;
        lf = seed;
        for (int c = 8; c < 16; c++) begin
            for (int g = 0; g < GENES; g++) begin
                pa  = c - 8;
                pb  = (pa + 1) % 8;
                sel = lf[0] ? parentVal(k, pb) : parentVal(k, pa);
                if (int'(lf[7:0]) < rate) sel = sel ^ (16'h1 << lf[11:8]);
                expImg[k][c * GENES + g] = sel;
                lf = lfsrStep(lf);
            end
        end
        lfOut = lf;
    endtask

    task automatic compareImage(input int k, input string tag);
        for (int i = 0; i < WORDS; i++)
            checkEq($sformatf("%s_w%0d", tag, i), mem[k][i],
                    (i < 8 * GENES) ? parentVal(k, i / GENES) : expImg[k][i]);
    endtask

    task automatic waitFinish(input int k, input string tag);
        int n = 0;
        while (fin[k] !== 1'b1 && n < 20000) begin
            tick(1);
            n++;
        end
        checkEq(tag, fin[k], 1);
    endtask

    task automatic restart(input int latency);
        rst_n = 1'b0;
        tick(2);
        initMem(0);
        lat[0] = latency;
        ns[0]  = 2'd3;
        rst_n  = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] lfEnd, lf22;
        int base, n, hits;
        checks = 0; errors = 0;
        for (int k = 0; k < 2; k++) begin
            strobes[k] = 0; widthErr[k] = 0; stabErr[k] = 0; lat[k] = 0; ns[k] = 2'd3;
            initMem(k);
        end
        rst_n = 1'b0;
        tick(6);
        checkEq("rst_fin0", fin[0], 0);
        checkEq("rst_fin1", fin[1], 0);
        checkEq("rst_strobes", strobes[0] + strobes[1], 0);
        checkEq("rst_lfsr", gRam[0].u.lfsr, 16'hACE1);

        // crossover-only and mutate-every-gene populations run side by side
        rst_n = 1'b1;
        waitFinish(0, "xover_done");
        waitFinish(1, "mut_done");
        checkEq("first_inst", stInst[0][0], 0);
        checkEq("first_addr", stAddr[0][0], 0);
        checkEq("second_addr", stAddr[0][1], 11);
        checkEq("first_wr_inst", stInst[0][2], 1);
        checkEq("first_wr_addr", stAddr[0][2], 88);
        checkEq("xover_strobes", strobes[0], 264);
        checkEq("mut_strobes", strobes[1], 264);
        checkEq("row8_g0", mem[0][88], 16'h1001);
        checkEq("row8_g1", mem[0][89], 16'h1000);
        checkEq("mut_g0", mem[1][88], 16'h1000);
        checkEq("mut_g1", mem[1][89], 16'h0004);
        modelImage(0, 16'hACE1, 0, lfEnd);
        compareImage(0, "xover");
        modelImage(1, 16'hACE1, 256, lfEnd);
        compareImage(1, "mut");
        checkEq("final_lfsr", gRam[0].u.lfsr, lfEnd);
        hits = 0;
        for (int g = 0; g < GENES; g++) begin
            if (mem[0][8 * GENES + g] == 16'h1000 || mem[0][8 * GENES + g] == 16'h1001) hits++;
            if (mem[0][15 * GENES + g] == 16'h1007 || mem[0][15 * GENES + g] == 16'h1000) hits++;
            if ($countones(mem[1][8 * GENES + g]) == 1) hits++;
        end
        checkEq("row_membership", hits, 3 * GENES);

        // completion hold, then release
        base = strobes[0];
        tick(50);
        checkEq("hold_strobes", strobes[0] - base, 0);
        checkEq("hold_fin", fin[0], 1);
        ns[0] = 2'd0;
        ns[1] = 2'd0;
        tick(1);
        checkEq("release_fin", fin[0], 0);

        // ready latency sweep must reproduce the same image
        foreach (lat[i]) lat[i] = 0;
        for (int li = 0; li < 2; li++) begin
            base = strobes[0];
            restart(li == 0 ? 1 : 5);
            waitFinish(0, "lat_done");
            checkEq("lat_strobes", strobes[0] - base, 264);
            compareImage(0, li == 0 ? "lat1" : "lat5");
        end

        // abort during the parent-B read of child 10
        base = strobes[0];
        restart(5);
        n = 0;
        while (strobes[0] < base + 68 && n < 20000) begin
            tick(1);
            n++;
        end
        checkEq("abort_reached", strobes[0] - base, 68);
        checkEq("abort_child", gRam[0].u.child, 10);
        ns[0] = 2'd2;
        #1;
        checkEq("abort_latch", gRam[0].latW === 1'b1, 0);
        tick(10);
        checkEq("abort_strobes", strobes[0] - base, 68);
        checkEq("abort_fin", fin[0], 0);
        lf22 = 16'hACE1;
        for (int i = 0; i < 22; i++) lf22 = lfsrStep(lf22);
        checkEq("abort_lfsr", gRam[0].u.lfsr, lf22);
        modelImage(0, lf22, 0, lfEnd);
        base = strobes[0];
        ns[0] = 2'd3;
        waitFinish(0, "reentry_done");
        checkEq("reentry_inst", stInst[0][base], 0);
        checkEq("reentry_addr", stAddr[0][base], 0);
        checkEq("reentry_addr_b", stAddr[0][base + 1], 11);
        checkEq("reentry_strobes", strobes[0] - base, 264);
        compareImage(0, "reentry");

        checkEq("latch_width", widthErr[0] + widthErr[1], 0);
        checkEq("bus_stable", stabErr[0] + stabErr[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
